// File: rtl/ioctl_sdram_loader.sv
// ioctl download stream -> SDRAM write port bridge with a small word FIFO and req/ack replay.
// Optional checksum output enabled by defining IOCTL_LOADER_CSUM_EN.
module ioctl_sdram_loader #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  INDEX_MATCH = 8'h00,
  parameter logic [24:0] BASE_ADDR   = 25'h0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
`ifdef IOCTL_LOADER_CSUM_EN
  output logic [15:0] checksum,
`endif
  output logic [23:0] word_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } wr_ent_t;

  typedef enum logic {IDLE, REQ} state_t;

  wr_ent_t        fifo [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_p1;
  logic [CW-1:0]  count, count_nxt;
  state_t         state, state_nxt;
  logic           match, full, push, drop, pop;
  logic           dl_q, rise, fall, drain, done_cond;
  logic           load, req_nxt;
  wr_ent_t        push_ent, head_ent, next_ent, ld_ent;

  assign match     = ioctl_download & ioctl_wr & (ioctl_index == INDEX_MATCH);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push      = match & ~full;
  assign drop      = match & full;
  assign pop       = (state == REQ) & mem_ack;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign rd_ptr_p1 = rd_ptr + 1'b1;

  assign push_ent.addr = BASE_ADDR + (ioctl_addr & 25'h1FF_FFFE);
  assign push_ent.data = ioctl_dout;
  // An empty FIFO forwards the incoming word so the request goes out the next cycle.
  assign head_ent  = (count != '0) ? fifo[rd_ptr] : push_ent;
  assign next_ent  = (count > CW'(1)) ? fifo[rd_ptr_p1] : push_ent;

  assign rise      = ioctl_download & ~dl_q;
  assign fall      = ~ioctl_download & dl_q;
  assign done_cond = drain & (count == '0) & (state == IDLE) & ~rise;
  assign busy      = ioctl_download | (count != '0) | mem_req | drain;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ld_ent    = head_ent;
    req_nxt   = mem_req;
    case (state)
      IDLE: if ((count != '0) || push) begin
        state_nxt = REQ;
        load      = 1'b1;
        req_nxt   = 1'b1;
      end
      REQ: if (mem_ack) begin
        if ((count > CW'(1)) || push) begin
          load   = 1'b1;
          ld_ent = next_ent;
        end else begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= state_nxt;
      mem_req <= req_nxt;
      if (load) begin
        mem_addr  <= ld_ent.addr;
        mem_wdata <= ld_ent.data;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
      dl_q       <= 1'b0;
      drain      <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_p1;
      count      <= count_nxt;
      ioctl_wait <= (count_nxt >= CW'(FIFO_DEPTH - 1));
      dl_q       <= ioctl_download;
      done       <= done_cond;
      if (fall)                  drain <= 1'b1;
      else if (rise | done_cond) drain <= 1'b0;
      overflow   <= (overflow & ~rise) | drop;
      if (rise)     word_count <= '0;
      else if (pop) word_count <= word_count + 24'd1;
    end
  end

`ifdef IOCTL_LOADER_CSUM_EN
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset)   checksum <= '0;
    else if (rise) checksum <= '0;
    else if (pop)  checksum <= checksum + mem_wdata;
  end
`endif
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Randomized bench for ioctl_sdram_loader against a queue-based reference of the loader's rules.
module tb_ioctl_sdram_loader;
  localparam int          DEPTH = 4;
  localparam logic [7:0]  MATCH = 8'h00;
  localparam logic [24:0] BASE  = 25'h80_0000;

  logic        clk_sys = 0, reset = 0;
  logic        ioctl_download = 0, ioctl_wr = 0, mem_ack = 0;
  logic [7:0]  ioctl_index = 0;
  logic [24:0] ioctl_addr = 0;
  logic [15:0] ioctl_dout = 0;
  logic        ioctl_wait, mem_req, busy, done, overflow;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [23:0] word_count;
`ifdef IOCTL_LOADER_CSUM_EN
  logic [15:0] checksum;
`endif

  ioctl_sdram_loader #(.FIFO_DEPTH(DEPTH), .INDEX_MATCH(MATCH), .BASE_ADDR(BASE)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy),
    .done(done), .overflow(overflow),
`ifdef IOCTL_LOADER_CSUM_EN
    .checksum(checksum),
`endif
    .word_count(word_count));

  initial forever #5 clk_sys = ~clk_sys;

  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a queue of words accepted but not yet acknowledged.
  typedef struct { logic [24:0] a; logic [15:0] d; } ent_t;
  ent_t q[$];
  int   m_wc = 0, n_writes = 0, done_cnt = 0;
  logic m_ovf = 0, m_wait = 0, m_drain = 0, m_done = 0, dl_prev = 0;
  logic [15:0] m_csum = 0;
  logic [24:0] last_addr = 0;
  int   ack_mode = 0;

  always @(negedge clk_sys) begin
    if (!reset) begin
      q.delete(); m_wc = 0; m_ovf = 0; m_wait = 0; m_drain = 0; m_done = 0;
      m_csum = 0; dl_prev = 0;
    end else begin
      logic acc, drp, rise, fall, empty_pre;
      ent_t e;
      chk("word_count", 32'(word_count), 32'(m_wc));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("ioctl_wait", 32'(ioctl_wait), 32'(m_wait));
      chk("done", 32'(done), 32'(m_done));
      chk("busy", 32'(busy), 32'(ioctl_download | (q.size() != 0) | m_drain));
      chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
`ifdef IOCTL_LOADER_CSUM_EN
      chk("checksum", 32'(checksum), 32'(m_csum));
`endif
      if (done) done_cnt++;
      acc  = ioctl_download & ioctl_wr & (ioctl_index == MATCH);
      drp  = acc && (q.size() >= DEPTH);
      rise = ioctl_download & ~dl_prev;
      fall = ~ioctl_download & dl_prev;
      empty_pre = (q.size() == 0);
      m_done = m_drain && empty_pre && !rise;
      if (m_done) m_drain = 0;
      if (rise) begin m_drain = 0; m_wc = 0; m_ovf = 0; m_csum = 0; end
      if (fall) m_drain = 1;
      if (drp) m_ovf = 1;
      if (mem_req && mem_ack && q.size() > 0) begin
        chk("wr_addr", 32'(mem_addr), 32'(q[0].a));
        chk("wr_data", 32'(mem_wdata), 32'(q[0].d));
        last_addr = mem_addr;
        n_writes++;
        if (!rise) begin m_wc++; m_csum = m_csum + q[0].d; end
        void'(q.pop_front());
      end
      if (acc && !drp) begin
        e.a = 25'((longint'(BASE) + longint'(ioctl_addr & 25'h1FF_FFFE)) % (longint'(1) << 25));
        e.d = ioctl_dout;
        q.push_back(e);
      end
      m_wait = (q.size() >= DEPTH - 1);
      dl_prev = ioctl_download;
    end
  end

  // SDRAM model: 0 = never ack, 1 = ack the cycle after req, 2 = random (also while idle).
  initial forever begin
    @(posedge clk_sys); #1;
    case (ack_mode)
      0:       mem_ack = 0;
      1:       mem_ack = mem_req && !mem_ack;
      default: mem_ack = ($urandom % 3) == 0;
    endcase
  end

  // Called at posedge+1; returns at posedge+1 after the strobe cycle.
  task automatic strobe(input logic [24:0] a, input logic [15:0] d, input logic [7:0] idx,
                        input bit honour);
    int n = 0;
    if (honour)
      while (ioctl_wait && n < 300) begin
        ioctl_wr = 0; @(posedge clk_sys); #1; n++;
      end
    if (n >= 300) chk("wait_timeout", 1, 0);
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d; ioctl_index = idx;
    @(posedge clk_sys); #1;
    ioctl_wr = 0;
  endtask

  task automatic finish_dl();
    int n = 0;
    ioctl_download = 0;
    @(posedge clk_sys); #1;
    while ((busy || mem_req) && n < 500) begin @(posedge clk_sys); #1; n++; end
    chk("drain_timeout", 32'(n < 500), 1);
    repeat (2) @(posedge clk_sys); #1;
  endtask

  initial begin
    int w0, d0;
    repeat (3) @(posedge clk_sys); #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wc", 32'(word_count), 0);
    reset = 1;
    @(posedge clk_sys); #1;

    // 1: eight words, ack one cycle after each request
    ack_mode = 1; w0 = n_writes; d0 = done_cnt;
    ioctl_download = 1;
    for (int i = 0; i < 8; i++) strobe(25'(2 * i), 16'(16'h1111 * (i + 1)), MATCH, 1);
    finish_dl();
    chk("t1_writes", 32'(n_writes - w0), 8);
    chk("t1_wc", 32'(word_count), 8);
    chk("t1_done", 32'(done_cnt - d0), 1);

    // 2: ack held low, host honours wait
    ack_mode = 0; ioctl_download = 1;
    for (int i = 0; i < 3; i++) strobe(25'(2 * i), 16'($urandom), MATCH, 1);
    chk("t2_wait_at_3", 32'(ioctl_wait), 1);
    chk("t2_no_ovf", 32'(overflow), 0);
    ack_mode = 2;
    for (int i = 3; i < 10; i++) strobe(25'(2 * i), 16'($urandom), MATCH, 1);
    finish_dl();
    chk("t2_wc", 32'(word_count), 10);
    chk("t2_no_ovf_end", 32'(overflow), 0);

    // 3: wait ignored with ack low
    ack_mode = 0; ioctl_download = 1; w0 = n_writes;
    for (int i = 0; i < 6; i++) strobe(25'(2 * i), 16'($urandom), MATCH, 0);
    chk("t3_ovf", 32'(overflow), 1);
    ack_mode = 1;
    finish_dl();
    chk("t3_writes", 32'(n_writes - w0), 4);
    chk("t3_wc", 32'(word_count), 4);

    // 4: address wrap and foreign index
    ack_mode = 1; ioctl_download = 1; w0 = n_writes;
    strobe(25'h1FF_FFFE, 16'hBEEF, MATCH, 1);
    strobe(25'h000_0010, 16'hDEAD, 8'h01, 1);
    finish_dl();
    chk("t4_wrap_addr", 32'(last_addr), 32'h07F_FFFE);
    chk("t4_writes", 32'(n_writes - w0), 1);
    chk("t4_ovf_cleared", 32'(overflow), 0);

    // 5: reset mid-transfer
    ack_mode = 0; ioctl_download = 1; w0 = n_writes;
    for (int i = 0; i < 3; i++) strobe(25'(2 * i), 16'($urandom), MATCH, 1);
    chk("t5_req_before", 32'(mem_req), 1);
    @(negedge clk_sys); #2;
    reset = 0; #1;
    chk("t5_req_async", 32'(mem_req), 0);
    ioctl_download = 0;
    repeat (2) @(posedge clk_sys); #1;
    reset = 1;
    @(negedge clk_sys); #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_wc", 32'(word_count), 0);
    ack_mode = 2;
    repeat (20) @(posedge clk_sys); #1;
    chk("t5_no_stray", 32'(n_writes - w0), 0);

`ifdef IOCTL_LOADER_CSUM_EN
    // 6: checksum wraps mod 2^16
    ack_mode = 1; ioctl_download = 1;
    strobe(25'h0, 16'hFFFF, MATCH, 1);
    strobe(25'h2, 16'h0002, MATCH, 1);
    finish_dl();
    chk("t6_csum", 32'(checksum), 32'h0001);
`endif

    // random downloads
    for (int r = 0; r < 6; r++) begin
      int n;
      ack_mode = 1 + ($urandom % 2); ioctl_download = 1; d0 = done_cnt;
      n = 5 + ($urandom % 16);
      for (int i = 0; i < n; i++)
        strobe(25'($urandom), 16'($urandom), (($urandom % 8) == 0) ? 8'h05 : MATCH,
               ($urandom % 5) != 0);
      if ($urandom % 2) repeat ($urandom % 4) @(posedge clk_sys);
      #0;
      finish_dl();
      chk("rnd_done", 32'(done_cnt - d0), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
